// File: rtl/wb_arbiter_if.sv
// Shared types and the bundled bus interface for wb_arbiter.
// wb_arbiter_pkg holds the wb_master command encoding; wb_arbiter_if groups
// the ibus, dbus and wb_master-side signals.
//   modport master : the arbiter's view (drives completions and master commands)
//   modport slave  : the environment's view (requesters plus wb_master)

package wb_arbiter_pkg;
  typedef enum logic [1:0] {
    WISHBONE_CMD_NONE  = 2'd0,
    WISHBONE_CMD_LOAD  = 2'd1,
    WISHBONE_CMD_STORE = 2'd2
  } wb_command_t;
endpackage

interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic        ibus_req_in;
  logic [31:0] ibus_addr_in;
  logic [31:0] ibus_rdata_out;
  logic        ibus_done_out;

  logic        dbus_req_in;
  logic        dbus_we_in;
  logic [31:0] dbus_addr_in;
  logic [31:0] dbus_wdata_in;
  logic [3:0]  dbus_wmask_in;
  logic [31:0] dbus_rdata_out;
  logic        dbus_done_out;

  wb_command_t cmd_out;
  logic        busy_in;
  logic [31:0] addr_out;
  logic [31:0] wdata_out;
  logic [3:0]  wmask_out;
  logic [31:0] rdata_in;
  logic [1:0]  owner_out;

  modport master (
    input  ibus_req_in, ibus_addr_in,
    output ibus_rdata_out, ibus_done_out,
    input  dbus_req_in, dbus_we_in, dbus_addr_in, dbus_wdata_in, dbus_wmask_in,
    output dbus_rdata_out, dbus_done_out,
    output cmd_out, addr_out, wdata_out, wmask_out, owner_out,
    input  busy_in, rdata_in
  );

  modport slave (
    output ibus_req_in, ibus_addr_in,
    input  ibus_rdata_out, ibus_done_out,
    output dbus_req_in, dbus_we_in, dbus_addr_in, dbus_wdata_in, dbus_wmask_in,
    input  dbus_rdata_out, dbus_done_out,
    input  cmd_out, addr_out, wdata_out, wmask_out, owner_out,
    output busy_in, rdata_in
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one wb_master command port between the instruction
// fetch bus (read-only) and the data bus. A winner is latched in IDLE, its
// command is presented for one cycle, and the master's busy rise/fall is
// tracked before read data and a one-cycle done pulse go back to the winner.
// Optional: WB_ARBITER_ROUND_ROBIN_EN replaces the fixed DBUS_PRIORITY tie
// break with alternation based on a last-owner register.

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter bit IBUS_WORD_ALIGN = 1'b1,
  parameter bit DBUS_PRIORITY   = 1'b1
) (
  input logic          clk_in,
  input logic          reset_in,
  wb_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_IBUS = 2'b01;
  localparam logic [1:0] OWNER_DBUS = 2'b10;

  state_t      state_q, state_d;
  wb_command_t cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] ibusRdata_q, ibusRdata_d;
  logic [31:0] dbusRdata_q, dbusRdata_d;
  logic        ibusDone_q, ibusDone_d;
  logic        dbusDone_q, dbusDone_d;
  logic [1:0]  owner_q, owner_d;
  logic        isStore_q, isStore_d;
  logic        grantDbus;
  logic [31:0] ibusAddr;

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  // 0 = ibus was granted last, 1 = dbus was granted last
  logic        lastDbus_q, lastDbus_d;
`endif

  assign ibusAddr = IBUS_WORD_ALIGN ? {bus.ibus_addr_in[31:2], 2'b00} : bus.ibus_addr_in;

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  // Tie goes to whichever port was not granted last; a lone requester wins
  always_comb begin
    grantDbus = bus.dbus_req_in && (!bus.ibus_req_in || !lastDbus_q);
  end
`else
  // Fixed priority tie break
  always_comb begin
    grantDbus = bus.dbus_req_in && (!bus.ibus_req_in || DBUS_PRIORITY);
  end
`endif

  // Next-state and registered-output logic for the transaction sequencer
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ibusRdata_d = ibusRdata_q;
    dbusRdata_d = dbusRdata_q;
    ibusDone_d  = 1'b0;
    dbusDone_d  = 1'b0;
    owner_d     = owner_q;
    isStore_d   = isStore_q;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
    lastDbus_d  = lastDbus_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.busy_in && (bus.ibus_req_in || bus.dbus_req_in)) begin
          state_d = ISSUE;
          if (grantDbus) begin
            owner_d   = OWNER_DBUS;
            addr_d    = bus.dbus_addr_in;
            wdata_d   = bus.dbus_wdata_in;
            wmask_d   = bus.dbus_we_in ? bus.dbus_wmask_in : 4'h0;
            cmd_d     = bus.dbus_we_in ? WISHBONE_CMD_STORE : WISHBONE_CMD_LOAD;
            isStore_d = bus.dbus_we_in;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
            lastDbus_d = 1'b1;
`endif
          end else begin
            owner_d   = OWNER_IBUS;
            addr_d    = ibusAddr;
            wdata_d   = 32'h0;
            wmask_d   = 4'h0;
            cmd_d     = WISHBONE_CMD_LOAD;
            isStore_d = 1'b0;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
            lastDbus_d = 1'b0;
`endif
          end
        end
      end
      ISSUE: begin
        cmd_d   = WISHBONE_CMD_NONE;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.busy_in) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.busy_in) begin
          state_d = DONE;
          if (owner_q == OWNER_DBUS) begin
            dbusDone_d = 1'b1;
            if (!isStore_q) begin
              dbusRdata_d = bus.rdata_in;
            end
          end else begin
            ibusDone_d  = 1'b1;
            ibusRdata_d = bus.rdata_in;
          end
        end
      end
      DONE: begin
        owner_d = OWNER_NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cmd_d   = WISHBONE_CMD_NONE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= IDLE;
      cmd_q       <= WISHBONE_CMD_NONE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wmask_q     <= 4'h0;
      ibusRdata_q <= 32'h0;
      dbusRdata_q <= 32'h0;
      ibusDone_q  <= 1'b0;
      dbusDone_q  <= 1'b0;
      owner_q     <= OWNER_NONE;
      isStore_q   <= 1'b0;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
      lastDbus_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ibusRdata_q <= ibusRdata_d;
      dbusRdata_q <= dbusRdata_d;
      ibusDone_q  <= ibusDone_d;
      dbusDone_q  <= dbusDone_d;
      owner_q     <= owner_d;
      isStore_q   <= isStore_d;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
      lastDbus_q  <= lastDbus_d;
`endif
    end
  end

  assign bus.cmd_out        = cmd_q;
  assign bus.addr_out       = addr_q;
  assign bus.wdata_out      = wdata_q;
  assign bus.wmask_out      = wmask_q;
  assign bus.owner_out      = owner_q;
  assign bus.ibus_rdata_out = ibusRdata_q;
  assign bus.ibus_done_out  = ibusDone_q;
  assign bus.dbus_rdata_out = dbusRdata_q;
  assign bus.dbus_done_out  = dbusDone_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with a single-cycle wb_master model.
// Cycle k of a window is the k-th falling edge after requests are applied.

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        modelBusy = 1'b0;
  logic        forceBusy = 1'b0;
  logic        holdReqs = 1'b0;
  logic [31:0] masterData = 32'h0;
  int          compared = 0;
  int          mismatched = 0;

  wb_command_t trCmd [0:31];
  logic [31:0] trAddr [0:31];
  logic [31:0] trWdata [0:31];
  logic [3:0]  trWmask [0:31];
  logic [1:0]  trOwner [0:31];
  logic        trIDone [0:31];
  logic        trDDone [0:31];
  logic [31:0] trIRdata [0:31];
  logic [31:0] trDRdata [0:31];

  wb_arbiter_if bus();

  wb_arbiter #(.IBUS_WORD_ALIGN(1'b1), .DBUS_PRIORITY(1'b1)) dut (
    .clk_in  (clk),
    .reset_in(rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // wb_master model: busy for the single cycle after a command is seen
  always @(posedge clk) begin
    modelBusy <= (bus.cmd_out != WISHBONE_CMD_NONE);
  end

  assign bus.busy_in  = modelBusy | forceBusy;
  assign bus.rdata_in = masterData;

  // Step n falling edges, recording outputs; requesters drop req on done
  task automatic runWindow(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      trCmd[k]    = bus.cmd_out;
      trAddr[k]   = bus.addr_out;
      trWdata[k]  = bus.wdata_out;
      trWmask[k]  = bus.wmask_out;
      trOwner[k]  = bus.owner_out;
      trIDone[k]  = bus.ibus_done_out;
      trDDone[k]  = bus.dbus_done_out;
      trIRdata[k] = bus.ibus_rdata_out;
      trDRdata[k] = bus.dbus_rdata_out;
      if (!holdReqs) begin
        if (bus.ibus_done_out) bus.ibus_req_in = 1'b0;
        if (bus.dbus_done_out) bus.dbus_req_in = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (bus.cmd_out !== WISHBONE_CMD_NONE || bus.owner_out !== 2'b00 ||
        bus.addr_out !== 32'h0 || bus.wdata_out !== 32'h0 || bus.wmask_out !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_cmd_side: cmd=%0d owner=%b addr=%h wdata=%h wmask=%h, required all zero",
               bus.cmd_out, bus.owner_out, bus.addr_out, bus.wdata_out, bus.wmask_out);
    end
    compared++;
    if (bus.ibus_done_out !== 1'b0 || bus.dbus_done_out !== 1'b0 ||
        bus.ibus_rdata_out !== 32'h0 || bus.dbus_rdata_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_req_side: idone=%b ddone=%b irdata=%h drdata=%h, required all zero",
               bus.ibus_done_out, bus.dbus_done_out, bus.ibus_rdata_out, bus.dbus_rdata_out);
    end
    rstN = 1'b1;
    runWindow(2);
  endtask

  task automatic test_ibus_load();
    int cnt;
    int at;
    int dcnt;
    masterData = 32'h0012_8293;
    bus.ibus_addr_in = 32'h0000_0103;
    bus.ibus_req_in = 1'b1;
    runWindow(6);
    compared++;
    if (trCmd[1] !== WISHBONE_CMD_LOAD || trAddr[1] !== 32'h0000_0100 ||
        trWmask[1] !== 4'h0 || trOwner[1] !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL ibus_issue: cmd=%0d addr=%h wmask=%h owner=%b, required 1 00000100 0 01",
               trCmd[1], trAddr[1], trWmask[1], trOwner[1]);
    end
    compared++;
    if (trCmd[2] !== WISHBONE_CMD_NONE) begin
      mismatched++;
      $display("[TB] FAIL ibus_cmd_one_cycle: cmd=%0d in cycle 2, required 0", trCmd[2]);
    end
    cnt = 0; at = 0; dcnt = 0;
    for (int k = 1; k <= 6; k++) begin
      if (trIDone[k]) begin cnt++; if (at == 0) at = k; end
      if (trDDone[k]) dcnt++;
    end
    compared++;
    if (cnt !== 1 || at !== 4 || dcnt !== 0) begin
      mismatched++;
      $display("[TB] FAIL ibus_done_pulse: count=%0d cycle=%0d dbus_count=%0d, required 1 4 0", cnt, at, dcnt);
    end
    compared++;
    if (trIRdata[4] !== 32'h0012_8293) begin
      mismatched++;
      $display("[TB] FAIL ibus_rdata: got %h, required 00128293", trIRdata[4]);
    end
    compared++;
    if (trOwner[5] !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL ibus_owner_release: got %b, required 00", trOwner[5]);
    end
  endtask

  task automatic test_simultaneous();
    int dAt;
    int iAt;
    int dCnt;
    int iCnt;
    masterData = 32'h1111_2222;
    bus.ibus_addr_in = 32'h0000_0208;
    bus.dbus_addr_in = 32'h2000_0040;
    bus.dbus_we_in = 1'b0;
    bus.dbus_wmask_in = 4'hF;
    bus.ibus_req_in = 1'b1;
    bus.dbus_req_in = 1'b1;
    runWindow(12);
    compared++;
    if (trOwner[1] !== 2'b10 || trCmd[1] !== WISHBONE_CMD_LOAD ||
        trAddr[1] !== 32'h2000_0040 || trWmask[1] !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL sim_first_grant: owner=%b cmd=%0d addr=%h wmask=%h, required 10 1 20000040 0",
               trOwner[1], trCmd[1], trAddr[1], trWmask[1]);
    end
    compared++;
    if (trOwner[6] !== 2'b01 || trCmd[6] !== WISHBONE_CMD_LOAD || trAddr[6] !== 32'h0000_0208) begin
      mismatched++;
      $display("[TB] FAIL sim_second_grant: owner=%b cmd=%0d addr=%h, required 01 1 00000208",
               trOwner[6], trCmd[6], trAddr[6]);
    end
    dAt = 0; iAt = 0; dCnt = 0; iCnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (trDDone[k]) begin dCnt++; if (dAt == 0) dAt = k; end
      if (trIDone[k]) begin iCnt++; if (iAt == 0) iAt = k; end
    end
    compared++;
    if (dCnt !== 1 || iCnt !== 1 || dAt !== 4 || iAt !== 9) begin
      mismatched++;
      $display("[TB] FAIL sim_done_spacing: dbus %0d@%0d ibus %0d@%0d, required 1@4 and 1@9",
               dCnt, dAt, iCnt, iAt);
    end
    compared++;
    if (trDRdata[4] !== 32'h1111_2222 || trIRdata[9] !== 32'h1111_2222) begin
      mismatched++;
      $display("[TB] FAIL sim_rdata: dbus=%h ibus=%h, required 11112222 11112222", trDRdata[4], trIRdata[9]);
    end
  endtask

  task automatic test_dbus_store();
    int cnt;
    int at;
    masterData = 32'h9999_9999;
    bus.dbus_addr_in = 32'h2000_0010;
    bus.dbus_wdata_in = 32'hDEAD_BEEF;
    bus.dbus_wmask_in = 4'b0011;
    bus.dbus_we_in = 1'b1;
    bus.dbus_req_in = 1'b1;
    runWindow(6);
    compared++;
    if (trCmd[1] !== WISHBONE_CMD_STORE || trAddr[1] !== 32'h2000_0010 || trWdata[1] !== 32'hDEAD_BEEF ||
        trWmask[1] !== 4'b0011 || trOwner[1] !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL store_issue: cmd=%0d addr=%h wdata=%h wmask=%h owner=%b, required 2 20000010 deadbeef 3 10",
               trCmd[1], trAddr[1], trWdata[1], trWmask[1], trOwner[1]);
    end
    cnt = 0; at = 0;
    for (int k = 1; k <= 6; k++) begin
      if (trDDone[k]) begin cnt++; if (at == 0) at = k; end
    end
    compared++;
    if (cnt !== 1 || at !== 4) begin
      mismatched++;
      $display("[TB] FAIL store_done_pulse: count=%0d cycle=%0d, required 1 4", cnt, at);
    end
    compared++;
    if (trDRdata[6] !== 32'h1111_2222 || trIRdata[6] !== 32'h1111_2222) begin
      mismatched++;
      $display("[TB] FAIL store_rdata_hold: dbus=%h ibus=%h, required 11112222 11112222", trDRdata[6], trIRdata[6]);
    end
    bus.dbus_we_in = 1'b0;
  endtask

  task automatic test_busy_hold();
    int issued;
    int at;
    masterData = 32'h0BAD_F00D;
    forceBusy = 1'b1;
    bus.ibus_addr_in = 32'h0000_0204;
    bus.ibus_req_in = 1'b1;
    runWindow(4);
    issued = 0;
    for (int k = 1; k <= 4; k++) begin
      if (trCmd[k] !== WISHBONE_CMD_NONE || trOwner[k] !== 2'b00) issued++;
    end
    compared++;
    if (issued !== 0) begin
      mismatched++;
      $display("[TB] FAIL busy_blocks_issue: %0d active cycles while busy, required 0", issued);
    end
    forceBusy = 1'b0;
    runWindow(6);
    compared++;
    if (trCmd[1] !== WISHBONE_CMD_LOAD || trAddr[1] !== 32'h0000_0204) begin
      mismatched++;
      $display("[TB] FAIL busy_release_issue: cmd=%0d addr=%h, required 1 00000204", trCmd[1], trAddr[1]);
    end
    at = 0;
    for (int k = 1; k <= 6; k++) if (trIDone[k] && at == 0) at = k;
    compared++;
    if (at !== 4 || trIRdata[4] !== 32'h0BAD_F00D) begin
      mismatched++;
      $display("[TB] FAIL busy_release_done: cycle=%0d rdata=%h, required 4 0badf00d", at, trIRdata[4]);
    end
  endtask

  task automatic test_reset_abort();
    int cnt;
    int at;
    masterData = 32'h1234_5678;
    bus.ibus_addr_in = 32'h0000_0300;
    bus.ibus_req_in = 1'b1;
    runWindow(2);
    forceBusy = 1'b1;
    runWindow(1);
    compared++;
    if (trOwner[1] !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL abort_in_flight: owner=%b, required 01", trOwner[1]);
    end
    rstN = 1'b0;
    #1;
    compared++;
    if (bus.cmd_out !== WISHBONE_CMD_NONE || bus.owner_out !== 2'b00 || bus.addr_out !== 32'h0 ||
        bus.wdata_out !== 32'h0 || bus.wmask_out !== 4'h0 ||
        bus.ibus_rdata_out !== 32'h0 || bus.dbus_rdata_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL abort_async_clear: cmd=%0d owner=%b addr=%h irdata=%h drdata=%h, required all zero",
               bus.cmd_out, bus.owner_out, bus.addr_out, bus.ibus_rdata_out, bus.dbus_rdata_out);
    end
    runWindow(2);
    forceBusy = 1'b0;
    compared++;
    if (trIDone[1] !== 1'b0 || trIDone[2] !== 1'b0 || trDDone[1] !== 1'b0 || trDDone[2] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_no_done: idone=%b%b ddone=%b%b, required 00 00",
               trIDone[1], trIDone[2], trDDone[1], trDDone[2]);
    end
    rstN = 1'b1;
    runWindow(6);
    cnt = 0; at = 0;
    for (int k = 1; k <= 6; k++) if (trIDone[k]) begin cnt++; if (at == 0) at = k; end
    compared++;
    if (trCmd[1] !== WISHBONE_CMD_LOAD || trAddr[1] !== 32'h0000_0300 || cnt !== 1 || at !== 4 ||
        trIRdata[4] !== 32'h1234_5678) begin
      mismatched++;
      $display("[TB] FAIL abort_reissue: cmd=%0d addr=%h done %0d@%0d rdata=%h, required 1 00000300 1@4 12345678",
               trCmd[1], trAddr[1], cnt, at, trIRdata[4]);
    end
  endtask

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  task automatic test_round_robin();
    holdReqs = 1'b1;
    bus.ibus_addr_in = 32'h0000_0400;
    bus.dbus_addr_in = 32'h2000_0400;
    bus.dbus_we_in = 1'b0;
    bus.ibus_req_in = 1'b1;
    bus.dbus_req_in = 1'b1;
    runWindow(20);
    compared++;
    if (trOwner[1] !== 2'b10 || trOwner[6] !== 2'b01 || trOwner[11] !== 2'b10 || trOwner[16] !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL rr_owner_sequence: %b %b %b %b, required 10 01 10 01",
               trOwner[1], trOwner[6], trOwner[11], trOwner[16]);
    end
    holdReqs = 1'b0;
    bus.ibus_req_in = 1'b0;
    bus.dbus_req_in = 1'b0;
    runWindow(6);
  endtask
`endif

  initial begin
    bus.ibus_req_in   = 1'b0;
    bus.ibus_addr_in  = 32'h0;
    bus.dbus_req_in   = 1'b0;
    bus.dbus_we_in    = 1'b0;
    bus.dbus_addr_in  = 32'h0;
    bus.dbus_wdata_in = 32'h0;
    bus.dbus_wmask_in = 4'h0;
    test_reset();
    test_ibus_load();
    test_simultaneous();
    test_dbus_store();
    test_busy_hold();
    test_reset_abort();
`ifdef WB_ARBITER_ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single core-side Wishbone master port between two requesters.
  - Instruction fetch (ibus): read-only.
  - Data load/store (dbus).
- Sits between the core pipeline and wb_master.
- Arbitrates, latches the winning request, sequences the master's command/busy protocol, and routes read data and completion back to the winner.

Parameters:
- IBUS_WORD_ALIGN, 1: when 1, ibus address bits [1:0] are forced to 0 on addr_out.
- DBUS_PRIORITY, 1: fixed-priority winner when both requesters are pending; 1 = dbus wins, 0 = ibus wins.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  asynchronous, active-low reset
- ibus_req_in  input  1  fetch request; held until ibus_done_out
- ibus_addr_in  input  32  fetch address
- ibus_rdata_out  output  32  fetch data; valid while ibus_done_out=1
- ibus_done_out  output  1  one-cycle completion pulse
- dbus_req_in  input  1  data request; held until dbus_done_out
- dbus_we_in  input  1  1 = store, 0 = load
- dbus_addr_in  input  32  data address
- dbus_wdata_in  input  32  store data
- dbus_wmask_in  input  4  store byte mask
- dbus_rdata_out  output  32  load data; valid while dbus_done_out=1
- dbus_done_out  output  1  one-cycle completion pulse
- cmd_out  output  wb_command_t  command to wb_master (WISHBONE_CMD_NONE/LOAD/STORE)
- busy_in  input  1  wb_master busy
- addr_out  output  32  address to wb_master
- wdata_out  output  32  write data to wb_master
- wmask_out  output  4  write mask to wb_master
- rdata_in  input  32  read data from wb_master
- owner_out  output  2  current owner: 00 none, 01 ibus, 10 dbus

Behaviour:
- Clock and reset: one clock, clk_in. Reset reset_in is asynchronous, active-low.
- Values forced while in reset:
  - cmd_out=WISHBONE_CMD_NONE
  - addr_out, wdata_out, ibus_rdata_out, dbus_rdata_out = 32'h0
  - wmask_out=4'h0
  - both done outputs = 0
  - owner_out=00
  - state=IDLE
- All outputs are registered.
- State machine: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> DONE -> IDLE.
- IDLE:
  - Stays in IDLE if busy_in=1 or no request is pending.
  - Otherwise selects a winner per arbitration rule.
  - Latches address (plus wdata/wmask/we for dbus) into addr_out/wdata_out/wmask_out.
  - Sets owner_out.
  - Sets cmd_out to LOAD (ibus, or dbus with we=0) or STORE (dbus with we=1).
  - Goes to ISSUE.
  - ibus address uses [1:0]=0 when IBUS_WORD_ALIGN=1.
  - ibus always issues LOAD; wmask_out=0 for ibus and dbus loads.
- ISSUE: cmd_out is non-NONE for exactly this one cycle. Then cmd_out<=NONE, go to WAIT_BUSY.
- WAIT_BUSY: wait for busy_in=1, then go to WAIT_DONE.
- WAIT_DONE: on busy_in=0:
  - LOAD: capture rdata_in into the owner's rdata_out.
  - Pulse the owner's done_out (registered, asserted during the DONE cycle).
  - Go to DONE.
- DONE:
  - The owner's done_out=1 for exactly this cycle; requests are not sampled.
  - Next state IDLE, owner_out<=00.
- rdata_out values:
  - A store leaves dbus_rdata_out unchanged.
  - Each rdata_out holds its last captured value until that port's next load completes.
- Latency with a single-cycle wb_master: request high in IDLE at cycle 0 -> done_out high in cycle 4. Back-to-back grants are separated by one IDLE cycle.
- Simultaneous requests in IDLE: winner per DBUS_PRIORITY, or per the optional feature. Loser stays pending and is granted in a later IDLE.
- A requester dropping req mid-transaction is a protocol violation; the transaction still completes and done is still pulsed.
- A requester still holding req in the cycle after DONE starts a new transaction.
- Reset asserted mid-transaction: immediate return to reset values; no done pulse for the aborted transaction.

Optional Feature:
- Macro: WB_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-owner register (reset: ibus) breaks ties in favour of the port not granted last.
  - DBUS_PRIORITY is ignored.
  - A single pending requester always wins.
- Undefined: fixed priority per DBUS_PRIORITY; no last-owner register.

Test Plan:
- Reset release; ibus_req_in=1, ibus_addr_in=32'h0000_0103 -> cmd_out=LOAD for one cycle with addr_out=32'h0000_0100. ibus_done_out pulses in cycle 4 with ibus_rdata_out=rdata_in (32'h00128293 from the master model).
- dbus store, addr 32'h2000_0010, wdata 32'hDEAD_BEEF, wmask 4'b0011 -> cmd_out=STORE with matching addr/wdata/wmask_out. dbus_done_out pulses once. dbus_rdata_out unchanged.
- Both requests asserted in the same cycle, DBUS_PRIORITY=1, macro undefined -> dbus served first, ibus served next. Done pulses are 5 cycles apart.
- WB_ARBITER_ROUND_ROBIN_EN defined, both requests held continuously for 4 transactions -> owner_out sequence is 10, 01, 10, 01.
- busy_in forced high while IDLE with ibus_req_in=1 -> cmd_out stays NONE until busy_in=0. Then the normal issue follows.
- reset_in pulled low during WAIT_DONE -> all outputs return to reset values asynchronously; no done pulse. After release, a held request re-issues from IDLE.
